// File: rtl/led_pattern_gen.sv
// Status/heartbeat LED driver: OFF, ON, BLINK, CHASE or PWM BREATHE patterns,
// stepped every cfg_period ticks of a CLK_FREQ/TICK_HZ prescaler.
`timescale 1ns/1ps
module led_pattern_gen #(
  parameter int unsigned LED_NUM  = 4,
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_mode,
  input  logic [15:0]        cfg_period,
  output logic [LED_NUM-1:0] led_out
);

  localparam int unsigned DIV_RAW = CLK_FREQ / TICK_HZ;
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W   = 16;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_CHASE   = 3'd3,
    MODE_BREATHE = 3'd4
  } mode_e;

  // Codes 5-7 collapse to OFF at acceptance so the active mode is always legal.
  function automatic mode_e decode_mode(input logic [2:0] m);
    case (m)
      3'd1:    return MODE_ON;
      3'd2:    return MODE_BLINK;
      3'd3:    return MODE_CHASE;
      3'd4:    return MODE_BREATHE;
      default: return MODE_OFF;
    endcase
  endfunction

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  mode_e               mode_q, mode_d;
  logic [CNT_W-1:0]    period_q, period_d;
  mode_e               pend_mode_q, pend_mode_d;
  logic [CNT_W-1:0]    pend_period_q, pend_period_d;
  logic                pend_q, pend_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic [LED_NUM-1:0]  led_q, led_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_up_q, dir_up_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;

  logic tick;
  logic step_evt;
  logic accept;
  logic pattern_mode;
  logic apply;

  assign tick         = (pre_q == PRE_LAST);
  assign step_evt     = tick && (cnt_q == period_q - 16'd1);
  assign accept       = cfg_valid && cfg_ready_q;
  assign pattern_mode = (mode_q == MODE_BLINK) || (mode_q == MODE_CHASE) ||
                        (mode_q == MODE_BREATHE);
  // Running patterns finish their current step before a new config lands.
  assign apply        = pend_q && (pattern_mode ? step_evt : tick);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_q         <= '0;
      cnt_q         <= '0;
      mode_q        <= MODE_OFF;
      period_q      <= 16'd1;
      pend_mode_q   <= MODE_OFF;
      pend_period_q <= 16'd1;
      pend_q        <= 1'b0;
      cfg_ready_q   <= 1'b1;
      led_q         <= '0;
      duty_q        <= '0;
      dir_up_q      <= 1'b1;
      pwm_q         <= '0;
    end else begin
      pre_q         <= pre_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      period_q      <= period_d;
      pend_mode_q   <= pend_mode_d;
      pend_period_q <= pend_period_d;
      pend_q        <= pend_d;
      cfg_ready_q   <= cfg_ready_d;
      led_q         <= led_d;
      duty_q        <= duty_d;
      dir_up_q      <= dir_up_d;
      pwm_q         <= pwm_d;
    end
  end

  always_comb begin
    pre_d         = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    period_d      = period_q;
    pend_mode_d   = pend_mode_q;
    pend_period_d = pend_period_q;
    pend_d        = pend_q;
    cfg_ready_d   = cfg_ready_q;
    led_d         = led_q;
    duty_d        = duty_q;
    dir_up_d      = dir_up_q;
    pwm_d         = pwm_q + PWM_BITS'(1);

    if (tick) begin
      cnt_d = step_evt ? '0 : cnt_q + 16'd1;
    end

    if (accept) begin
      pend_mode_d   = decode_mode(cfg_mode);
      pend_period_d = (cfg_period == 16'd0) ? 16'd1 : cfg_period;
      pend_d        = 1'b1;
      cfg_ready_d   = 1'b0;
    end

    case (mode_q)
      MODE_ON:    led_d = '1;
      MODE_BLINK: if (step_evt) led_d = ~led_q;
      MODE_CHASE: if (step_evt) led_d = (led_q << 1) | (led_q >> (LED_NUM - 1));
      MODE_BREATHE: begin
        led_d = {LED_NUM{pwm_q < duty_q}};
        // Triangle sweep: each end value is held for exactly one step.
        if (step_evt) begin
          if (dir_up_q) begin
            if (duty_q == DUTY_MAX) begin
              dir_up_d = 1'b0;
              duty_d   = duty_q - PWM_BITS'(1);
            end else begin
              duty_d   = duty_q + PWM_BITS'(1);
            end
          end else begin
            if (duty_q == '0) begin
              dir_up_d = 1'b1;
              duty_d   = duty_q + PWM_BITS'(1);
            end else begin
              duty_d   = duty_q - PWM_BITS'(1);
            end
          end
        end
      end
      default:    led_d = '0;
    endcase

    if (apply) begin
      mode_d      = pend_mode_q;
      period_d    = pend_period_q;
      cnt_d       = '0;
      pend_d      = 1'b0;
      cfg_ready_d = 1'b1;
      case (pend_mode_q)
        MODE_ON, MODE_BLINK: led_d = '1;
        MODE_CHASE:          led_d = LED_NUM'(1);
        MODE_BREATHE: begin
          led_d    = '0;
          duty_d   = '0;
          dir_up_d = 1'b1;
        end
        default:             led_d = '0;
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign led_out   = led_q;

endmodule
